// File: rtl/dcfir_pkg.sv
// rtl/dcfir_pkg.sv - shared types, width helpers and rounding constant for dcfir_frac_delay
package dcfir_pkg;

  // Storage width of one complex sample; must equal the DW of the filter instance.
  localparam int CPLX_W = 16;

  typedef enum logic {
    ST_FILL = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // "real" is a reserved word, so the components are named re/im.
  typedef struct packed {
    logic signed [CPLX_W-1:0] re;
    logic signed [CPLX_W-1:0] im;
  } cplx_t;

  function automatic int prod_w(input int dw, input int cw);
    return dw + cw;
  endfunction

  function automatic int acc_w(input int dw, input int cw, input int ntaps);
    return dw + cw + 1 + $clog2(ntaps);
  endfunction

  // Half an output LSB, added before the arithmetic shift for round-half-up.
  function automatic longint round_const(input int shift);
    return (shift > 0) ? (64'sd1 <<< (shift - 1)) : 64'sd0;
  endfunction

endpackage

// File: rtl/dcfir_frac_delay_if.sv
// rtl/dcfir_frac_delay_if.sv - sample, coefficient and result signals of the fractional-delay FIR
interface dcfir_frac_delay_if #(
  parameter int DW    = 16,
  parameter int CW    = 10,
  parameter int DEPTH = 32,
  parameter int NTAPS = 4,
  parameter int OW    = 16
);
  localparam int SW = $clog2(DEPTH);
  localparam int IW = $clog2(NTAPS);

  logic                 in_valid;
  logic signed [DW-1:0] din_real;
  logic signed [DW-1:0] din_imag;
  logic [SW-1:0]        sel;
  logic                 flush;
  logic                 coef_wr;
  logic [IW-1:0]        coef_idx;
  logic signed [CW-1:0] coef_real;
  logic signed [CW-1:0] coef_imag;
  logic                 coef_commit;
  logic                 out_valid;
  logic signed [OW-1:0] dout_real;
  logic signed [OW-1:0] dout_imag;
  logic                 primed;

  modport master (
    output in_valid, din_real, din_imag, sel, flush,
    output coef_wr, coef_idx, coef_real, coef_imag, coef_commit,
    input  out_valid, dout_real, dout_imag, primed
  );

  modport slave (
    input  in_valid, din_real, din_imag, sel, flush,
    input  coef_wr, coef_idx, coef_real, coef_imag, coef_commit,
    output out_valid, dout_real, dout_imag, primed
  );

endinterface

// File: rtl/dcfir_cmac.sv
// rtl/dcfir_cmac.sv - registered complex multiplier for one filter tap (stage S2)
module dcfir_cmac
  import dcfir_pkg::*;
#(
  parameter int DW = 16,
  parameter int CW = 10
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic signed [DW-1:0]          x_re,
  input  logic signed [DW-1:0]          x_im,
  input  logic signed [CW-1:0]          c_re,
  input  logic signed [CW-1:0]          c_im,
  output logic signed [prod_w(DW,CW):0] p_re,
  output logic signed [prod_w(DW,CW):0] p_im
);
  localparam int PW = prod_w(DW, CW);

  logic signed [PW-1:0] rr, ii, ri, ir;

  assign rr = PW'(x_re) * PW'(c_re);
  assign ii = PW'(x_im) * PW'(c_im);
  assign ri = PW'(x_re) * PW'(c_im);
  assign ir = PW'(x_im) * PW'(c_re);

  // Combine the partial products one bit wider so the sum/difference cannot overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_re <= '0;
      p_im <= '0;
    end else begin
      p_re <= {rr[PW-1], rr} - {ii[PW-1], ii};
      p_im <= {ri[PW-1], ri} + {ir[PW-1], ir};
    end
  end

endmodule

// File: rtl/dcfir_frac_delay.sv
// rtl/dcfir_frac_delay.sv - complex fractional-delay FIR top; DCFIR_SAT_EN selects output saturation
module dcfir_frac_delay
  import dcfir_pkg::*;
#(
  parameter int DW    = 16,
  parameter int CW    = 10,
  parameter int DEPTH = 32,
  parameter int NTAPS = 4,
  parameter int OW    = 16,
  parameter int SHIFT = 9
) (
  input logic              clk,
  input logic              rst_n,
  dcfir_frac_delay_if.slave bus
);
  localparam int SW = $clog2(DEPTH);
  localparam int IW = $clog2(NTAPS);
  localparam int MW = prod_w(DW, CW) + 1;
  localparam int AW = acc_w(DW, CW, NTAPS);
  localparam logic signed [AW:0] RND = (AW+1)'(round_const(SHIFT));
`ifdef DCFIR_SAT_EN
  localparam logic signed [AW:0] OMAX = (AW+1)'((64'sd1 <<< (OW - 1)) - 64'sd1);
  localparam logic signed [AW:0] OMIN = (AW+1)'(-(64'sd1 <<< (OW - 1)));
`endif

  // A sample is discarded when flush arrives in the same cycle.
  logic accept;
  assign accept = bus.in_valid & ~bus.flush;

  cplx_t dline [DEPTH];
  cplx_t xs    [DEPTH];
  cplx_t win   [NTAPS];

  logic signed [CW-1:0] sh_re [NTAPS];
  logic signed [CW-1:0] sh_im [NTAPS];
  logic signed [CW-1:0] ac_re [NTAPS];
  logic signed [CW-1:0] ac_im [NTAPS];

  state_t        state, state_next;
  logic [SW:0]   fill_cnt;

  cplx_t                s1_x    [NTAPS];
  logic signed [CW-1:0] s1_c_re [NTAPS];
  logic signed [CW-1:0] s1_c_im [NTAPS];
  logic                 s1_valid;
  logic signed [MW-1:0] s2_re   [NTAPS];
  logic signed [MW-1:0] s2_im   [NTAPS];
  logic                 s2_valid;
  logic signed [AW-1:0] sum_re, sum_im;
  logic signed [AW-1:0] s3_re, s3_im;
  logic                 s3_valid;
  logic signed [AW:0]   rnd_re, rnd_im, sc_re, sc_im;
  logic signed [OW-1:0] dout_re_q, dout_im_q;
  logic                 out_valid_q;

  // Delay line as it looks with the incoming sample already shifted in: xs[0] is the newest.
  always_comb begin
    xs[0].re = CPLX_W'(bus.din_real);
    xs[0].im = CPLX_W'(bus.din_imag);
    for (int j = 1; j < DEPTH; j++) begin
      xs[j] = dline[j-1];
    end
  end

  // Shift the delay line on every accepted sample; flush clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int j = 0; j < DEPTH; j++) dline[j] <= '0;
    end else if (bus.flush) begin
      for (int j = 0; j < DEPTH; j++) dline[j] <= '0;
    end else if (bus.in_valid) begin
      for (int j = 0; j < DEPTH; j++) dline[j] <= xs[j];
    end
  end

  // Tap k reads x[sel+k]; positions past the end of the line read as zero rather than wrapping.
  for (genvar k = 0; k < NTAPS; k++) begin : g_win
    logic [SW+3:0] pos;
    assign pos    = (SW+4)'(bus.sel) + (SW+4)'(k);
    assign win[k] = (pos <= (SW+4)'(DEPTH - 1)) ? xs[pos[SW-1:0]] : '0;
  end

  // Shadow writes, and the commit copy into the active bank (a same-cycle write is included).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NTAPS; k++) begin
        sh_re[k] <= '0;
        sh_im[k] <= '0;
        ac_re[k] <= '0;
        ac_im[k] <= '0;
      end
    end else begin
      for (int k = 0; k < NTAPS; k++) begin
        if (bus.coef_wr && bus.coef_idx == IW'(k)) begin
          sh_re[k] <= bus.coef_real;
          sh_im[k] <= bus.coef_imag;
        end
        if (bus.coef_commit) begin
          if (bus.coef_wr && bus.coef_idx == IW'(k)) begin
            ac_re[k] <= bus.coef_real;
            ac_im[k] <= bus.coef_imag;
          end else begin
            ac_re[k] <= sh_re[k];
            ac_im[k] <= sh_im[k];
          end
        end
      end
    end
  end

  // Fill-state register and the accepted-sample counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_FILL;
      fill_cnt <= '0;
    end else begin
      state <= state_next;
      if (bus.flush) begin
        fill_cnt <= '0;
      end else if (accept && state == ST_FILL) begin
        fill_cnt <= fill_cnt + 1'b1;
      end
    end
  end

  // Next state: RUN once the DEPTH-th sample is accepted, back to FILL on flush.
  always_comb begin
    state_next = state;
    case (state)
      ST_FILL: if (accept && fill_cnt == (SW+1)'(DEPTH - 1)) state_next = ST_RUN;
      ST_RUN:  if (bus.flush) state_next = ST_FILL;
      default: state_next = ST_FILL;
    endcase
  end

  // State-derived output.
  always_comb begin
    bus.primed = (state == ST_RUN);
  end

  // S1: register the tap window and the active coefficients seen by this sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      for (int k = 0; k < NTAPS; k++) begin
        s1_x[k]    <= '0;
        s1_c_re[k] <= '0;
        s1_c_im[k] <= '0;
      end
    end else begin
      s1_valid <= accept;
      if (accept) begin
        for (int k = 0; k < NTAPS; k++) begin
          s1_x[k]    <= win[k];
          s1_c_re[k] <= ac_re[k];
          s1_c_im[k] <= ac_im[k];
        end
      end
    end
  end

  // S2: one complex multiplier per tap.
  for (genvar k = 0; k < NTAPS; k++) begin : g_cmac
    dcfir_cmac #(.DW(DW), .CW(CW)) u_cmac (
      .clk   (clk),
      .rst_n (rst_n),
      .x_re  (DW'(s1_x[k].re)),
      .x_im  (DW'(s1_x[k].im)),
      .c_re  (s1_c_re[k]),
      .c_im  (s1_c_im[k]),
      .p_re  (s2_re[k]),
      .p_im  (s2_im[k])
    );
  end

  // The valid bit travels alongside the products.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) s2_valid <= 1'b0;
    else        s2_valid <= s1_valid;
  end

  // S3 adder tree: sign-extended sum of all tap products.
  always_comb begin
    sum_re = '0;
    sum_im = '0;
    for (int k = 0; k < NTAPS; k++) begin
      sum_re = sum_re + AW'(s2_re[k]);
      sum_im = sum_im + AW'(s2_im[k]);
    end
  end

  // S3 register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s3_re    <= '0;
      s3_im    <= '0;
      s3_valid <= 1'b0;
    end else begin
      s3_re    <= sum_re;
      s3_im    <= sum_im;
      s3_valid <= s2_valid;
    end
  end

  // Reduce a scaled value to OW bits: clamp when saturation is built in, otherwise wrap.
  function automatic logic signed [OW-1:0] reduce(input logic signed [AW:0] v);
`ifdef DCFIR_SAT_EN
    if (v > OMAX)      return OW'(OMAX);
    else if (v < OMIN) return OW'(OMIN);
    else               return OW'(v);
`else
    return OW'(v);
`endif
  endfunction

  // Round half up, then arithmetic shift; one guard bit keeps the bias add from overflowing.
  always_comb begin
    rnd_re = (AW+1)'(s3_re) + RND;
    rnd_im = (AW+1)'(s3_im) + RND;
    sc_re  = rnd_re >>> SHIFT;
    sc_im  = rnd_im >>> SHIFT;
  end

  // S4 output register; dout holds its last result between strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_re_q   <= '0;
      dout_im_q   <= '0;
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= s3_valid;
      if (s3_valid) begin
        dout_re_q <= reduce(sc_re);
        dout_im_q <= reduce(sc_im);
      end
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.dout_real = dout_re_q;
  assign bus.dout_imag = dout_im_q;

endmodule

// File: tb/tb_dcfir_frac_delay.sv
// tb/tb_dcfir_frac_delay.sv - scoreboard bench for dcfir_frac_delay
module tb_dcfir_frac_delay;
  localparam int DW    = 16;
  localparam int CW    = 10;
  localparam int DEPTH = 32;
  localparam int NTAPS = 4;
  localparam int OW    = 16;
  localparam int SHIFT = 9;
  localparam int SW    = $clog2(DEPTH);
  localparam int IW    = $clog2(NTAPS);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dcfir_frac_delay_if #(.DW(DW), .CW(CW), .DEPTH(DEPTH), .NTAPS(NTAPS), .OW(OW)) bus ();

  dcfir_frac_delay #(
    .DW(DW), .CW(CW), .DEPTH(DEPTH), .NTAPS(NTAPS), .OW(OW), .SHIFT(SHIFT)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    longint re;
    longint im;
  } exp_t;
  exp_t sb[$];

  longint m_re [DEPTH];
  longint m_im [DEPTH];
  longint s_re [NTAPS];
  longint s_im [NTAPS];
  longint a_re [NTAPS];
  longint a_im [NTAPS];
  int     m_fill;
  bit     m_primed;

  task automatic check(input string tag, input longint obs, input longint expv);
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, expv);
    end
  endtask

  function automatic longint scale(input longint acc);
    longint v;
    logic [OW-1:0] t;
    v = (acc + (longint'(1) <<< (SHIFT - 1))) >>> SHIFT;
`ifdef DCFIR_SAT_EN
    if (v > (longint'(1) <<< (OW - 1)) - 1) v = (longint'(1) <<< (OW - 1)) - 1;
    if (v < -(longint'(1) <<< (OW - 1)))    v = -(longint'(1) <<< (OW - 1));
    return v;
`else
    t = v[OW-1:0];
    return longint'($signed(t));
`endif
  endfunction

  task automatic model_reset();
    for (int j = 0; j < DEPTH; j++) begin
      m_re[j] = 0;
      m_im[j] = 0;
    end
    for (int k = 0; k < NTAPS; k++) begin
      s_re[k] = 0; s_im[k] = 0; a_re[k] = 0; a_im[k] = 0;
    end
    m_fill   = 0;
    m_primed = 0;
  endtask

  // Drive one clock cycle of stimulus, advance the model, and push the expected result.
  task automatic cycle(input bit v, input longint re, input longint im, input int s,
                       input bit fl, input bit wr, input int idx,
                       input longint cre, input longint cim, input bit cm);
    longint yr, yi;
    exp_t e;
    bus.in_valid    = v;
    bus.din_real    = DW'(re);
    bus.din_imag    = DW'(im);
    bus.sel         = SW'(s);
    bus.flush       = fl;
    bus.coef_wr     = wr;
    bus.coef_idx    = IW'(idx);
    bus.coef_real   = CW'(cre);
    bus.coef_imag   = CW'(cim);
    bus.coef_commit = cm;
    if (fl) begin
      for (int j = 0; j < DEPTH; j++) begin
        m_re[j] = 0;
        m_im[j] = 0;
      end
      m_fill   = 0;
      m_primed = 0;
    end else if (v) begin
      for (int j = DEPTH - 1; j > 0; j--) begin
        m_re[j] = m_re[j-1];
        m_im[j] = m_im[j-1];
      end
      m_re[0] = re;
      m_im[0] = im;
      yr = 0;
      yi = 0;
      for (int k = 0; k < NTAPS; k++) begin
        if (s + k < DEPTH) begin
          yr += m_re[s+k] * a_re[k] - m_im[s+k] * a_im[k];
          yi += m_re[s+k] * a_im[k] + m_im[s+k] * a_re[k];
        end
      end
      e.re = scale(yr);
      e.im = scale(yi);
      sb.push_back(e);
      if (!m_primed) begin
        m_fill++;
        if (m_fill == DEPTH) m_primed = 1;
      end
    end
    if (wr) begin
      s_re[idx] = cre;
      s_im[idx] = cim;
    end
    if (cm) begin
      for (int k = 0; k < NTAPS; k++) begin
        a_re[k] = s_re[k];
        a_im[k] = s_im[k];
      end
    end
    @(posedge clk);
    #1;
    check("primed", bus.primed, longint'(m_primed));
    bus.in_valid    = 1'b0;
    bus.flush       = 1'b0;
    bus.coef_wr     = 1'b0;
    bus.coef_commit = 1'b0;
  endtask

  task automatic smp(input longint re, input longint im, input int s);
    cycle(1, re, im, s, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic wcoef(input int idx, input longint cre, input longint cim);
    cycle(0, 0, 0, 0, 0, 1, idx, cre, cim, 0);
  endtask

  task automatic commit();
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
  endtask

  task automatic do_flush();
    cycle(0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
  endtask

  function automatic longint rnd_sample();
    return longint'($urandom_range(65535)) - 32768;
  endfunction

  function automatic longint rnd_coef();
    return longint'($urandom_range(1023)) - 512;
  endfunction

  // Output monitor: every strobe must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && bus.out_valid) begin
      if (sb.size() == 0) begin
        check("unexpected_out_valid", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("dout_real", bus.dout_real, e.re);
        check("dout_imag", bus.dout_imag, e.im);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    bus.in_valid = 0; bus.din_real = '0; bus.din_imag = '0; bus.sel = '0;
    bus.flush = 0; bus.coef_wr = 0; bus.coef_idx = '0; bus.coef_real = '0;
    bus.coef_imag = '0; bus.coef_commit = 0;

    // Reset state
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_dout_real", bus.dout_real, 0);
    check("rst_dout_imag", bus.dout_imag, 0);
    check("rst_primed", bus.primed, 0);
    rst_n = 1'b1;

    // Impulse through tap0 = 511
    wcoef(0, 511, 0);
    commit();
    smp(1000, 0, 0);
    repeat (8) smp(0, 0, 0);

    // Complex multiply: (100+200j)*(0+511j)
    wcoef(0, 0, 511);
    commit();
    smp(100, 200, 0);
    repeat (6) smp(0, 0, 0);

    // Integer delay select, then window running into zero padding
    wcoef(0, 511, 0);
    commit();
    do_flush();
    smp(1000, 0, 5);
    repeat (8) smp(0, 0, 5);
    for (int k = 0; k < NTAPS; k++) wcoef(k, 100 + 50 * k, -30 * k);
    commit();
    repeat (40) smp(rnd_sample(), rnd_sample(), 30);
    repeat (5) smp(rnd_sample(), rnd_sample(), 31);

    // Commit coinciding with a sample uses the old bank; write+commit together is included
    for (int k = 0; k < NTAPS; k++) wcoef(k, (k == 0) ? 511 : 0, 0);
    commit();
    do_flush();
    wcoef(0, 256, 0);
    cycle(1, 1000, 0, 0, 0, 0, 0, 0, 0, 1);
    smp(1000, 0, 0);
    cycle(0, 0, 0, 0, 0, 1, 1, -200, 77, 1);
    repeat (4) smp(rnd_sample(), rnd_sample(), 0);

    // Saturation / wrap with constant full-scale input
    for (int k = 0; k < NTAPS; k++) wcoef(k, 511, 0);
    commit();
    repeat (40) smp(32767, 0, 0);

    // Flush after 10 samples; flush with in_valid discards; refill from zero
    do_flush();
    repeat (10) smp(rnd_sample(), rnd_sample(), 2);
    cycle(1, 12345, -777, 0, 1, 0, 0, 0, 0, 0);
    repeat (DEPTH - 1) smp(rnd_sample(), rnd_sample(), 1);
    check("primed_before_full", bus.primed, 0);
    smp(rnd_sample(), rnd_sample(), 1);
    check("primed_after_full", bus.primed, 1);

    // Randomised traffic with gaps, flushes and coefficient churn
    for (int i = 0; i < 300; i++) begin
      cycle(($urandom_range(3) != 0), rnd_sample(), rnd_sample(), int'($urandom_range(DEPTH - 1)),
            ($urandom_range(39) == 0), ($urandom_range(3) == 0), int'($urandom_range(NTAPS - 1)),
            rnd_coef(), rnd_coef(), ($urandom_range(9) == 0));
    end
    idle(6);

    // Reset dropped mid-burst: outputs clear at once and nothing in flight emerges
    repeat (3) smp(rnd_sample(), rnd_sample(), 0);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", bus.out_valid, 0);
    check("midrst_dout_real", bus.dout_real, 0);
    check("midrst_dout_imag", bus.dout_imag, 0);
    check("midrst_primed", bus.primed, 0);
    sb.delete();
    model_reset();
    idle(2);
    rst_n = 1'b1;
    idle(8);
    wcoef(0, 300, -100);
    commit();
    repeat (5) smp(rnd_sample(), rnd_sample(), 0);

    idle(10);
    check("scoreboard_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
